// File: rtl/behaviour_arbiter.sv
// behaviour_arbiter: subsumption arbiter that shares the two drive motors between
// three behaviours with fixed priority avoid > home > wander. Homing is time-limited.
// After HOME_MAX_S ticks of homing it is locked out for COOLDOWN_S ticks, and
// home_enable is withdrawn for the duration of that lockout.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   in_enable    global run enable; low stops the motors and clears all timers
//   avoid_req    avoid behaviour requests control
//   avoid_cmd    avoid motor command {left[1:0], right[1:0]}
//   home_req     home behaviour requests control
//   home_cmd     home motor command
//   wander_cmd   default motor command
//   motor_cmd    registered command to the motor drivers (00 stop, 01 fwd, 10 back)
//   active       current owner: 00 idle, 01 wander, 10 home, 11 avoid
//   home_enable  enables the timed homing block
//   home_timeout one-cycle pulse when the homing time expires
module behaviour_arbiter #(
  parameter int unsigned TICK_DIV   = 12000000,
  parameter int unsigned HOME_MAX_S = 5,
  parameter int unsigned COOLDOWN_S = 3,
  parameter int unsigned AVOID_HOLD = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_enable,
  input  logic       avoid_req,
  input  logic [3:0] avoid_cmd,
  input  logic       home_req,
  input  logic [3:0] home_cmd,
  input  logic [3:0] wander_cmd,
  output logic [3:0] motor_cmd,
  output logic [1:0] active,
  output logic       home_enable,
  output logic       home_timeout
);

  // TICK_DIV must be at least 1.
  localparam logic [31:0] TickLast     = 32'(TICK_DIV - 1);
  localparam logic [31:0] HomeMax      = 32'(HOME_MAX_S);
  localparam logic [31:0] CooldownLoad = 32'(COOLDOWN_S);
  localparam logic [31:0] HoldLoad     = 32'(AVOID_HOLD);
  localparam logic        HomeLimited  = (HOME_MAX_S != 0);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWander = 2'b01,
    StHome   = 2'b10,
    StAvoid  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] home_timer_q, home_timer_d;
  logic [31:0] cooldown_q, cooldown_d;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  motor_q, motor_d;
  logic        home_enable_q, home_enable_d;
  logic        home_timeout_q, home_timeout_d;
  logic        tick;
  logic        timeout;

  // Per-motor code 11 is illegal and becomes stop on that motor only.
  function automatic logic [3:0] sanitize(input logic [3:0] cmd);
    logic [3:0] s;
    s = cmd;
    if (cmd[3:2] == 2'b11) s[3:2] = 2'b00;
    if (cmd[1:0] == 2'b11) s[1:0] = 2'b00;
    return s;
  endfunction

  always_comb begin
    tick           = 1'b0;
    timeout        = 1'b0;
    presc_d        = presc_q;
    home_timer_d   = home_timer_q;
    cooldown_d     = cooldown_q;
    hold_d         = hold_q;
    state_d        = state_q;
    motor_d        = 4'b0000;
    home_enable_d  = 1'b0;
    home_timeout_d = 1'b0;

    if (!in_enable) begin
      presc_d      = '0;
      home_timer_d = '0;
      cooldown_d   = '0;
      hold_d       = '0;
      state_d      = StIdle;
    end else begin
      tick    = (presc_q == TickLast);
      presc_d = tick ? '0 : presc_q + 32'd1;

      // The timer may sit at the limit while AVOID owns the motors; the
      // timeout still fires then, it just cannot take the motors.
      timeout = home_req && HomeLimited && (home_timer_q == HomeMax);

      if (!home_req || timeout) begin
        home_timer_d = '0;
      end else if (state_q == StHome && tick && HomeLimited) begin
        home_timer_d = home_timer_q + 32'd1;
      end

      if (timeout) begin
        cooldown_d = CooldownLoad;
      end else if (tick && cooldown_q != '0) begin
        cooldown_d = cooldown_q - 32'd1;
      end

      if (avoid_req) begin
        hold_d = HoldLoad;
      end else if (state_q == StAvoid && hold_q != '0) begin
        hold_d = hold_q - 32'd1;
      end else begin
        hold_d = '0;
      end

      if (avoid_req || (state_q == StAvoid && hold_q != '0)) begin
        state_d = StAvoid;
      end else if (home_req && cooldown_q == '0 && !timeout) begin
        state_d = StHome;
      end else begin
        state_d = StWander;
      end

      // Low on the timeout edge itself and for every cycle the lockout is held.
      home_enable_d  = (cooldown_q == '0) && (cooldown_d == '0);
      home_timeout_d = timeout;
    end

    unique case (state_d)
      StAvoid:  motor_d = sanitize(avoid_cmd);
      StHome:   motor_d = sanitize(home_cmd);
      StWander: motor_d = sanitize(wander_cmd);
      default:  motor_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      home_timer_q   <= '0;
      cooldown_q     <= '0;
      hold_q         <= '0;
      motor_q        <= 4'b0000;
      home_enable_q  <= 1'b0;
      home_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      home_timer_q   <= home_timer_d;
      cooldown_q     <= cooldown_d;
      hold_q         <= hold_d;
      motor_q        <= motor_d;
      home_enable_q  <= home_enable_d;
      home_timeout_q <= home_timeout_d;
    end
  end

  assign motor_cmd    = motor_q;
  assign active       = state_q;
  assign home_enable  = home_enable_q;
  assign home_timeout = home_timeout_q;

endmodule

// File: tb/tb_behaviour_arbiter.sv
// Testbench for behaviour_arbiter: directed scenarios plus randomized traffic.
// Stimulus pushes expected outputs into a scoreboard queue, and a monitor pops them
// after every clock edge.
module tb_behaviour_arbiter;

  localparam int TickDiv   = 4;
  localparam int HomeMax   = 2;
  localparam int Cooldown  = 3;
  localparam int AvoidHold = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_enable = 1'b0;
  logic       avoid_req = 1'b0;
  logic [3:0] avoid_cmd = 4'h0;
  logic       home_req = 1'b0;
  logic [3:0] home_cmd = 4'h0;
  logic [3:0] wander_cmd = 4'h0;
  logic [3:0] motor_cmd;
  logic [1:0] active;
  logic       home_enable;
  logic       home_timeout;

  behaviour_arbiter #(
    .TICK_DIV  (TickDiv),
    .HOME_MAX_S(HomeMax),
    .COOLDOWN_S(Cooldown),
    .AVOID_HOLD(AvoidHold)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_enable   (in_enable),
    .avoid_req   (avoid_req),
    .avoid_cmd   (avoid_cmd),
    .home_req    (home_req),
    .home_cmd    (home_cmd),
    .wander_cmd  (wander_cmd),
    .motor_cmd   (motor_cmd),
    .active      (active),
    .home_enable (home_enable),
    .home_timeout(home_timeout)
  );

  always #5 clk = ~clk;

  // exp = {motor_cmd, active, home_enable, home_timeout}; obs marks a counting window.
  typedef struct packed {
    logic [7:0] exp;
    logic       obs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   obs_cnt[4];
  int   obs_to;
  int   obs_he0;
  bit   obs_flag = 1'b0;

  // Reference model: time spent homing, lockout left, avoid linger, current owner.
  int m_phase, m_homed, m_cool, m_linger, m_owner;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("outputs {motor,active,home_en,timeout}",
            {motor_cmd, active, home_enable, home_timeout}, mon_e.exp);
      if (mon_e.obs) begin
        obs_cnt[active]++;
        if (home_timeout) obs_to++;
        if (!home_enable) obs_he0++;
      end
    end
  end

  function automatic logic [3:0] legal(input logic [3:0] c);
    int l, r;
    l = c[3:2];
    r = c[1:0];
    if (l > 2) l = 0;
    if (r > 2) r = 0;
    return 4'(l * 4 + r);
  endfunction

  task automatic model_clear();
    m_phase = 0; m_homed = 0; m_cool = 0; m_linger = 0; m_owner = 0;
  endtask

  task automatic clear_obs();
    foreach (obs_cnt[i]) obs_cnt[i] = 0;
    obs_to  = 0;
    obs_he0 = 0;
  endtask

  task automatic step(input bit en, input bit ar, input logic [3:0] ac,
                      input bit hr, input logic [3:0] hc, input logic [3:0] wc);
    bit         tick, expire, he;
    int         owner;
    logic [3:0] mc;
    exp_t       e;
    @(negedge clk);
    in_enable = en; avoid_req = ar; avoid_cmd = ac;
    home_req = hr; home_cmd = hc; wander_cmd = wc;
    expire = 1'b0;
    he     = 1'b0;
    mc     = 4'h0;
    if (!en) begin
      model_clear();
    end else begin
      tick   = (m_phase == TickDiv - 1);
      expire = hr && (m_homed == HomeMax);
      if (ar || (m_owner == 3 && m_linger > 0)) owner = 3;
      else if (hr && m_cool == 0 && !expire) owner = 2;
      else owner = 1;
      he = (m_cool == 0) && !expire;
      if (!hr || expire) m_homed = 0;
      else if (m_owner == 2 && tick) m_homed++;
      if (expire) m_cool = Cooldown;
      else if (tick && m_cool > 0) m_cool--;
      if (ar) m_linger = AvoidHold;
      else if (m_owner == 3 && m_linger > 0) m_linger--;
      else m_linger = 0;
      m_phase = tick ? 0 : m_phase + 1;
      m_owner = owner;
      mc = (owner == 3) ? legal(ac) : (owner == 2) ? legal(hc) : legal(wc);
    end
    e.exp = {mc, 2'(m_owner), he, expire};
    e.obs = obs_flag;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; in_enable = 1'b0; avoid_req = 1'b0; home_req = 1'b0;
    avoid_cmd = 4'h0; home_cmd = 4'h0; wander_cmd = 4'h0;
    model_clear();
    #1;
    check("reset outputs", {motor_cmd, active, home_enable, home_timeout}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  bit         r_en, r_ar, r_hr;
  logic [3:0] r_ac, r_hc, r_wc;

  initial begin
    clear_obs();
    model_clear();
    do_reset();

    // Wander with no requests.
    repeat (3) step(1, 0, 4'h0, 0, 4'h0, 4'b0101);

    // Held home_req: 8 HOME cycles, one timeout, 12 cycles of lockout.
    do_reset();
    clear_obs();
    obs_flag = 1'b1;
    repeat (20) step(1, 0, 4'h0, 1, 4'b0110, 4'b0101);
    obs_flag = 1'b0;
    settle();
    check("home cycles before timeout", obs_cnt[2], 8);
    check("timeout pulses", obs_to, 1);
    check("home_enable low cycles", obs_he0, 12);
    check("wander cycles during lockout", obs_cnt[1], 12);
    repeat (4) step(1, 0, 4'h0, 1, 4'b0110, 4'b0101);

    // Avoid preempts HOME for 3 cycles; home timer must survive.
    do_reset();
    repeat (5) step(1, 0, 4'h0, 1, 4'b0110, 4'b0101);
    clear_obs();
    obs_flag = 1'b1;
    repeat (3) step(1, 1, 4'b1010, 1, 4'b0110, 4'b0101);
    repeat (15) step(1, 0, 4'b1010, 1, 4'b0110, 4'b0101);
    obs_flag = 1'b0;
    settle();
    check("avoid cycles", obs_cnt[3], 3 + AvoidHold);
    check("home cycles after avoid", obs_cnt[2], 4);
    check("timeout after avoid", obs_to, 1);

    // Illegal per-motor codes.
    repeat (2) step(1, 1, 4'b1110, 0, 4'h0, 4'b0101);
    repeat (2) step(1, 1, 4'b1011, 0, 4'h0, 4'b0101);
    repeat (2) step(1, 0, 4'h0, 0, 4'h0, 4'b1111);

    // Drop in_enable during HOME, then the full homing time is available again.
    do_reset();
    repeat (6) step(1, 0, 4'h0, 1, 4'b0110, 4'b0101);
    repeat (2) step(0, 0, 4'h0, 1, 4'b0110, 4'b0101);
    clear_obs();
    obs_flag = 1'b1;
    repeat (12) step(1, 0, 4'h0, 1, 4'b0110, 4'b0101);
    obs_flag = 1'b0;
    settle();
    check("home cycles after re-enable", obs_cnt[2], 8);

    // Asynchronous reset in the middle of AVOID.
    repeat (3) step(1, 1, 4'b1010, 0, 4'h0, 4'b0101);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async reset outputs", {motor_cmd, active, home_enable, home_timeout}, 0);
    model_clear();
    in_enable = 1'b0; avoid_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic.
    r_ar = 1'b0;
    r_hr = 1'b0;
    repeat (2000) begin
      r_en = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 5) == 0) r_ar = ~r_ar;
      if ($urandom_range(0, 19) == 0) r_hr = ~r_hr;
      r_ac = 4'($urandom);
      r_hc = 4'($urandom);
      r_wc = 4'($urandom);
      step(r_en, r_ar, r_ac, r_hr, r_hc, r_wc);
    end
    settle();
    check("scoreboard drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
